pipe_inv_div: RTL



---
 rtl/pipe_inv_div.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pipe_inv_div.sv
// pipe_inv_div: sequential restoring divider, q = f / d and r = f % d, one
// quotient bit per clock, with valid/ready handshakes on both sides.
// Optional feature macro: PIPE_INV_DIV_REM_EN. When it is defined, the remainder
// output register is built. When it is undefined, r is tied to zero.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | in_ready=1, waiting for an operand pair
// BUSY  | one restoring step per cycle, MSB first (or zero-divisor fill)
// DONE  | out_valid=1, q/r/div_zero held until out_ready
module pipe_inv_div #(
   parameter int N = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] f,
   input  logic [N-1:0] d,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] q,
   output logic [N-1:0] r,
   output logic         div_zero
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [N-1:0]  dvd;
   logic [N-1:0]  dsr;
   logic [N-1:0]  rem;
   logic          zero_pend;
   logic [N:0]    rem_sh;
   logic [N:0]    rem_diff;
   logic          q_bit;
   logic [N-1:0]  rem_nxt;
   logic [N-1:0]  quo_nxt;
   logic          accept;
   logic          last_step;

   assign accept    = (state == IDLE) && in_valid;
   assign last_step = (state == BUSY) && (cnt == '0);

   // One restoring step: shift in the next dividend bit, trial-subtract on N+1 bits.
   always_comb begin
      rem_sh   = {rem, dvd[N-1]};
      rem_diff = rem_sh - {1'b0, dsr};
      q_bit    = ~rem_diff[N];
      rem_nxt  = q_bit ? rem_diff[N-1:0] : rem_sh[N-1:0];
      quo_nxt  = {dvd[N-2:0], q_bit};
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = BUSY;
         BUSY:    if (cnt == '0) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs are plain decodes of the registered state.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // Iteration datapath. The zero-divisor case spends a single BUSY cycle so
   // its result lands on the edge t+1, with the same DONE-entry path as division.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         dvd       <= '0;
         dsr       <= '0;
         rem       <= '0;
         zero_pend <= 1'b0;
      end else if (accept) begin
         dvd       <= f;
         dsr       <= d;
         rem       <= '0;
         zero_pend <= (d == '0);
         cnt       <= (d == '0) ? '0 : CW'(N - 1);
      end else if (state == BUSY) begin
         cnt <= cnt - CW'(1);
         if (!zero_pend) begin
            dvd <= quo_nxt;
            rem <= rem_nxt;
         end
      end
   end

   // Result registers change only on the edge entering DONE, or on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         q        <= '0;
         div_zero <= 1'b0;
      end else if (last_step) begin
         q        <= zero_pend ? '1 : quo_nxt;
         div_zero <= zero_pend;
      end
   end

`ifdef PIPE_INV_DIV_REM_EN
   logic [N-1:0] r_reg;

   // Final remainder; a zero divisor returns the dividend itself.
   always_ff @(posedge clk) begin
      if (rst)            r_reg <= '0;
      else if (last_step) r_reg <= zero_pend ? dvd : rem_nxt;
   end

   assign r = r_reg;
`else
   assign r = '0;
`endif

endmodule
